// File: rtl/soc_ahb_pkg.sv
// Shared AHB-Lite definitions for the system bus: transfer types, master IDs
// and transfer sizes, plus a helper that tells whether a transfer type
// carries a real beat.
package soc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic MID_CPU = 1'b0;
  localparam logic MID_AUX = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // NONSEQ and SEQ are the only transfer types that move data.
  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_master_arb2.sv
// Two-master AHB-Lite arbiter. Master 0 is the CPU and master 1 an auxiliary
// master. Ownership moves only on HREADY-qualified edges, locked sequences
// are never split, and a hold counter bounds tenure while the other master
// is waiting.
module ahb_master_arb2
  import soc_ahb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        M0_HBUSREQ,
  input  logic        M1_HBUSREQ,
  input  logic        M0_HLOCK,
  input  logic        M1_HLOCK,
  output logic        M0_HGRANT,
  output logic        M1_HGRANT,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  input  logic [31:0] S_HRDATA,
  output logic        HMASTER,
  output logic        HMASTLOCK
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic          grant;
  logic          addr_owner;
  logic          data_owner;
  logic          lock_d;
  logic [CW-1:0] hold_cnt;

  logic          o_req;
  logic          x_req;
  logic [1:0]    o_trans;
  logic          switch_ok;
  logic          own_move;

  // Address-phase mux: the address owner's signals reach the fabric; the
  // other master's address phase is ignored.
  always_comb begin
    S_HADDR   = M0_HADDR;
    S_HTRANS  = M0_HTRANS;
    S_HWRITE  = M0_HWRITE;
    S_HSIZE   = M0_HSIZE;
    HMASTLOCK = M0_HLOCK;
    o_req     = M0_HBUSREQ;
    x_req     = M1_HBUSREQ;
    o_trans   = M0_HTRANS;
    if (addr_owner == MID_AUX) begin
      S_HADDR   = M1_HADDR;
      S_HTRANS  = M1_HTRANS;
      S_HWRITE  = M1_HWRITE;
      S_HSIZE   = M1_HSIZE;
      HMASTLOCK = M1_HLOCK;
      o_req     = M1_HBUSREQ;
      x_req     = M0_HBUSREQ;
      o_trans   = M1_HTRANS;
    end else begin
      S_HADDR   = M0_HADDR;
      S_HTRANS  = M0_HTRANS;
      S_HWRITE  = M0_HWRITE;
      S_HSIZE   = M0_HSIZE;
      HMASTLOCK = M0_HLOCK;
      o_req     = M0_HBUSREQ;
      x_req     = M1_HBUSREQ;
      o_trans   = M0_HTRANS;
    end
  end

  // Data-phase mux: write data follows the owner of the previous address phase.
  always_comb begin
    S_HWDATA = M0_HWDATA;
    if (data_owner == MID_AUX) begin
      S_HWDATA = M1_HWDATA;
    end else begin
      S_HWDATA = M0_HWDATA;
    end
  end

  // Handover is allowed only with no handover pending and no lock in force
  // (lock_d keeps the transfer after HLOCK falls with the current owner).
  assign switch_ok = (grant == addr_owner) && x_req && !HMASTLOCK && !lock_d &&
                     (!o_req || (hold_cnt == HOLD_LIM));
  assign own_move  = S_HREADY && (grant != addr_owner);

  assign M0_HGRANT = ~grant;
  assign M1_HGRANT = grant;
  assign HMASTER   = addr_owner;
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = S_HREADY;
  assign M1_HREADY = S_HREADY;

  // Grant register: moves to the other master when switch_ok, parks otherwise.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant <= MID_CPU;
    end else if (switch_ok) begin
      grant <= ~addr_owner;
    end else begin
      grant <= grant;
    end
  end

  // Ownership pipeline: advances only on HREADY-qualified edges.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner <= MID_CPU;
      data_owner <= MID_CPU;
      lock_d     <= 1'b0;
    end else if (S_HREADY) begin
      addr_owner <= grant;
      data_owner <= addr_owner;
      lock_d     <= HMASTLOCK;
    end else begin
      addr_owner <= addr_owner;
      data_owner <= data_owner;
      lock_d     <= lock_d;
    end
  end

  // Tenure counter: counts the owner's accepted beats while the other
  // master waits; cleared on ownership change or when nobody is waiting.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_cnt <= CNT_ZERO;
    end else if (own_move || !x_req) begin
      hold_cnt <= CNT_ZERO;
    end else if (S_HREADY && trans_active(o_trans) && (hold_cnt != HOLD_LIM)) begin
      hold_cnt <= hold_cnt + CNT_ONE;
    end else begin
      hold_cnt <= hold_cnt;
    end
  end

endmodule

// File: tb/tb_ahb_master_arb2.sv
// Directed-vector bench for ahb_master_arb2 with HOLD_MAX = 4: a table of
// per-cycle inputs and expected grant/ownership, a beat scoreboard, and a
// hand-written reset-mid-burst sequence.
module tb_ahb_master_arb2;
  import soc_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        M0_HBUSREQ, M1_HBUSREQ, M0_HLOCK, M1_HLOCK;
  logic        M0_HGRANT, M1_HGRANT;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HREADY, M1_HREADY;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HREADY, HMASTER, HMASTLOCK;
  logic [2:0]  S_HSIZE;

  ahb_master_arb2 #(.HOLD_MAX(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HBUSREQ(M0_HBUSREQ), .M1_HBUSREQ(M1_HBUSREQ),
    .M0_HLOCK(M0_HLOCK), .M1_HLOCK(M1_HLOCK),
    .M0_HGRANT(M0_HGRANT), .M1_HGRANT(M1_HGRANT),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA),
    .M0_HREADY(M0_HREADY),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA),
    .M1_HREADY(M1_HREADY),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HRDATA(S_HRDATA), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  localparam logic [1:0] TI = HTRANS_IDLE;
  localparam logic [1:0] TN = HTRANS_NONSEQ;
  localparam logic [1:0] TS = HTRANS_SEQ;

  // Inputs for one cycle and the state expected right after its edge.
  typedef struct {
    logic       r0, r1, l0, l1;
    logic [1:0] t0, t1;
    logic       rdy;
    logic       g, ao, dow;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [31:0] addr_of(input logic m, input int i);
    return m ? (32'h2000_0000 + 32'(i * 4)) : (32'h1000_0000 + 32'(i * 4));
  endfunction

  task automatic drive(input vec_t v, input int i);
    M0_HBUSREQ = v.r0;  M1_HBUSREQ = v.r1;
    M0_HLOCK   = v.l0;  M1_HLOCK   = v.l1;
    M0_HTRANS  = v.t0;  M1_HTRANS  = v.t1;
    M0_HADDR   = addr_of(1'b0, i);
    M1_HADDR   = addr_of(1'b1, i);
    M0_HWDATA  = 32'hD000_0000 + 32'(i);
    M1_HWDATA  = 32'hE000_0000 + 32'(i);
    S_HRDATA   = 32'hA5A5_0000 + 32'(i);
    S_HREADY   = v.rdy;
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, i, act, expv);
    end
  endtask

  task automatic chk_state(input int i, input logic g, input logic ao, input logic dow);
    n_vec++;
    chk("m1_hgrant", i, {31'd0, M1_HGRANT}, {31'd0, g});
    chk("m0_hgrant", i, {31'd0, M0_HGRANT}, {31'd0, !g});
    chk("hmaster",   i, {31'd0, HMASTER},   {31'd0, ao});
    chk("hmastlock", i, {31'd0, HMASTLOCK}, {31'd0, (ao ? M1_HLOCK : M0_HLOCK)});
    chk("s_haddr",   i, S_HADDR,            (ao ? M1_HADDR : M0_HADDR));
    chk("s_htrans",  i, {30'd0, S_HTRANS},  {30'd0, (ao ? M1_HTRANS : M0_HTRANS)});
    chk("s_hwrite",  i, {31'd0, S_HWRITE},  {31'd0, (ao ? M1_HWRITE : M0_HWRITE)});
    chk("s_hsize",   i, {29'd0, S_HSIZE},   {29'd0, (ao ? M1_HSIZE : M0_HSIZE)});
    chk("s_hwdata",  i, S_HWDATA,           (dow ? M1_HWDATA : M0_HWDATA));
    chk("m0_hrdata", i, M0_HRDATA,          S_HRDATA);
    chk("m1_hrdata", i, M1_HRDATA,          S_HRDATA);
    chk("m0_hready", i, {31'd0, M0_HREADY}, {31'd0, S_HREADY});
    chk("m1_hready", i, {31'd0, M1_HREADY}, {31'd0, S_HREADY});
  endtask

  initial begin
    logic  p;
    logic [1:0] pt;
    vec_t  v;

    //                  r0    r1    l0    l1    t0  t1  rdy   g     ao    dow
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, TI, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 0 idle
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, TI, TN, 1'b1, 1'b1, 1'b0, 1'b0}); // 1 grant to M1
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, TI, TN, 1'b1, 1'b1, 1'b1, 1'b0}); // 2 M1 owns
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, TI, TN, 1'b1, 1'b1, 1'b1, 1'b1}); // 3 M1 data phase
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, TI, TI, 1'b1, 1'b0, 1'b1, 1'b1}); // 4 back to M0
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, TN, TI, 1'b1, 1'b0, 1'b0, 1'b1}); // 5
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TN, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 6 beat 1
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TS, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 7 beat 2
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TS, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 8 beat 3
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TS, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 9 beat 4
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TS, TI, 1'b1, 1'b1, 1'b0, 1'b0}); // 10 hold limit
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TS, TN, 1'b1, 1'b1, 1'b1, 1'b0}); // 11
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TS, 1'b1, 1'b1, 1'b1, 1'b1}); // 12 count restarted
    tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, TI, TI, 1'b1, 1'b0, 1'b1, 1'b1}); // 13
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, TN, TI, 1'b1, 1'b0, 1'b0, 1'b1}); // 14 lock starts
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, TN, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 15 locked 1
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, TS, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 16 locked 2
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 1'b0, TS, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 17 locked 3
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, TN, TI, 1'b1, 1'b0, 1'b0, 1'b0}); // 18 lock_d gap
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 1'b0, TI, TI, 1'b1, 1'b1, 1'b0, 1'b0}); // 19 grant moves
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TN, 1'b0, 1'b1, 1'b0, 1'b0}); // 20 wait
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TN, 1'b0, 1'b1, 1'b0, 1'b0}); // 21 wait
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TN, 1'b0, 1'b1, 1'b0, 1'b0}); // 22 wait
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TN, 1'b1, 1'b1, 1'b1, 1'b0}); // 23 switch
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TS, 1'b1, 1'b1, 1'b1, 1'b1}); // 24

    M0_HWRITE = 1'b1;  M0_HSIZE = HSIZE_WORD;
    M1_HWRITE = 1'b0;  M1_HSIZE = HSIZE_HALF;
    drive(tbl[0], 0);

    // Reset held: M0 owns, outputs select M0.
    repeat (2) @(posedge HCLK);
    #1;
    chk_state(100, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    chk_state(101, 1'b0, 1'b0, 1'b0);

    // Table run, capturing every HREADY-qualified active beat for the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], i);
      #1;
      if (S_HREADY && S_HTRANS[1]) got_q.push_back(S_HADDR);
      p  = (i == 0) ? 1'b0 : tbl[i-1].ao;
      pt = p ? tbl[i].t1 : tbl[i].t0;
      if (tbl[i].rdy && pt[1]) exp_q.push_back(addr_of(p, i));
      @(posedge HCLK);
      #1;
      chk_state(i, tbl[i].g, tbl[i].ao, tbl[i].dow);
    end

    chk("beat_count", 200, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk("beat_addr", 200 + k, got_q[k], exp_q[k]);
    end

    // Reset mid-burst of M1: outputs return to M0 immediately.
    v = vec_t'{1'b0, 1'b1, 1'b0, 1'b0, TI, TS, 1'b1, 1'b1, 1'b1, 1'b1};
    drive(v, 30);
    @(posedge HCLK);
    #1;
    chk_state(30, 1'b1, 1'b1, 1'b1);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_state(31, 1'b0, 1'b0, 1'b0);

    // After reset M0 requests but stays idle: M1 traffic stays off the bus.
    v = vec_t'{1'b1, 1'b1, 1'b0, 1'b0, TI, TN, 1'b1, 1'b0, 1'b0, 1'b0};
    drive(v, 32);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge HCLK);
      #1;
      chk_state(32 + k, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
